// File: rtl/puf_resp_serializer.sv
// Streams a captured 128-bit PUF response as 16-bit words, MS word first,
// with an optional XOR checksum word and a resend of the last capture.
module puf_resp_serializer #(
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] puf_resp,
  input  logic         puf_done,
  input  logic         resend,
  output logic [15:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         word_last,
  output logic [3:0]   word_idx,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);
  localparam logic [3:0] LAST = CHECKSUM_EN ? 4'd8 : 4'd7;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nx;

  logic         puf_done_q;
  logic [127:0] shreg, hold;
  logic [15:0]  csum;
  logic [3:0]   idx;
  logic         rise, start, xfer, at_last;
  logic [127:0] src;

  function automatic logic [15:0] xor_fold(input logic [127:0] v);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ v[16*i +: 16];
    return acc;
  endfunction

  assign rise    = puf_done & ~puf_done_q;
  assign start   = (state == IDLE) && (rise || resend);
  // A fresh edge always beats a resend request in the same cycle.
  assign src     = rise ? puf_resp : hold;
  assign xfer    = word_valid & word_ready;
  assign at_last = (idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise || resend) state_nx = SEND;
      SEND:    if (xfer && at_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      puf_done_q <= 1'b0;
      shreg      <= '0;
      hold       <= '0;
      csum       <= '0;
      idx        <= '0;
      overrun    <= 1'b0;
    end else begin
      puf_done_q <= puf_done;
      if (start) begin
        shreg <= src;
        csum  <= xor_fold(src);
        idx   <= '0;
        if (rise) hold <= puf_resp;
      end else if (state == SEND && xfer && !at_last) begin
        shreg <= {shreg[111:0], 16'h0000};
        idx   <= idx + 4'd1;
      end else if (state == DONE) begin
        idx <= '0;
      end
      // Edges that land mid-frame are flagged but never start a capture.
      if (rise && state != IDLE) overrun <= 1'b1;
    end
  end

  assign word_valid = (state == SEND);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);
  assign word_idx   = idx;
  assign word_last  = word_valid && at_last;
  assign word_out   = !word_valid ? 16'h0000 :
                      (idx == 4'd8) ? csum : shreg[127:112];
endmodule

// File: doc/puf_resp_serializer.md
# puf_resp_serializer

Consumer-side companion to the 128-bit PUF response collector. Captures the completed 128-bit response when the collector raises its done flag. Streams the response as eight 16-bit words over a valid/ready interface, most-significant word first, matching the order in which the collector assembled it. An optional ninth XOR-checksum word follows, and the last captured response can be re-sent without re-running the PUF.

## Interface

Parameters
- CHECKSUM_EN, default 1: 1 appends a ninth word equal to the XOR of the eight data words; 0 sends eight words only.

Ports
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- puf_resp  in  128  response from collector, sampled only at capture
- puf_done  in  1  collector done flag; level, held high until the collector is reset
- resend  in  1  single-cycle request to retransmit the last captured response
- word_out  out  16  current word; forced to 0 whenever word_valid = 0
- word_valid  out  1  word_out holds a valid word
- word_ready  in  1  downstream accepts the word; transfer = word_valid & word_ready
- word_last  out  1  high with word_valid on the final word of a frame
- word_idx  out  4  index of the current word, 0..8
- busy  out  1  frame in progress (state SEND or DONE)
- frame_done  out  1  one-cycle pulse after the final transfer
- overrun  out  1  sticky; a new response arrived while busy

## Operation

- Registered puf_done_q detects the rising edge: `edge = puf_done & ~puf_done_q`. puf_done_q resets to 0, so puf_done already high at reset release counts as an edge.
- LAST = 8 if CHECKSUM_EN else 7.
- States: IDLE, SEND, DONE.
- IDLE:
  - On edge: shreg <= puf_resp, csum <= XOR of the eight 16-bit slices, word_idx <= 0, word_valid <= 1, go to SEND.
  - Else, on resend: reload shreg from the saved copy (hold register written at every capture), recompute csum, then proceed as above.
  - Edge and resend in the same cycle: edge wins, and the new response is captured.
- SEND:
  - word_out = shreg[127:112] while word_idx < 8; word_out = csum when word_idx = 8.
  - On each transfer:
    - If word_idx = LAST: word_valid <= 0, frame_done <= 1, go to DONE.
    - Otherwise: shreg shifts left 16, word_idx increments.
- DONE: frame_done <= 0, word_idx <= 0, go to IDLE.
- Because puf_done stays high, a held puf_done never causes a retransmit. A new capture needs puf_done to fall and rise again.
- In SEND or DONE:
  - An edge sets overrun (it stays set until reset) and is otherwise ignored.
  - resend is ignored.
- word_ready while word_valid = 0 has no effect.
- word_idx, word_last and word_out are all derived from registered state. No combinational path from word_ready to any output.

## Timing

- Reset (asynchronous, immediate):
  - Outputs: word_out = 0, word_valid = 0, word_last = 0, word_idx = 0, busy = 0, frame_done = 0, overrun = 0.
  - Internal: state = IDLE, puf_done_q = 0, shreg/csum/hold = 0.
- Capture latency: edge sampled at rising edge N; word_valid, busy and word 0 are visible after edge N. Equivalently, puf_done high during cycle N-1 gives word_valid in cycle N.
- Throughput: one word per cycle while word_ready = 1. A full frame takes 9 cycles (8 if CHECKSUM_EN = 0).
- Stall: while word_valid = 1 and word_ready = 0, word_out, word_idx and word_last hold stable.
- frame_done is high for exactly the one cycle after the final transfer; busy is also high that cycle. IDLE is reached one cycle later.
- Minimum gap between frames: 2 cycles (DONE, then IDLE).
- Reset mid-frame: frame aborted immediately, no frame_done. After release, a still-high puf_done starts a fresh capture.

## Test plan

1. **Reset:** rst = 0 with random inputs -> every output 0. Release with puf_done = 0 -> remains IDLE, word_valid = 0.
2. **Streaming, checksum on:** CHECKSUM_EN = 1, puf_resp = 0x0001_0002_0003_0004_0005_0006_0007_0008, puf_done rises, word_ready = 1 -> words 0x0001..0x0008 on consecutive cycles, then 0x0008 (checksum). word_last only on idx 8. frame_done one cycle later. No further words while puf_done is held.
3. **Backpressure:** puf_resp = 0x5468697349734E6F74576F726B696E67, word_ready toggling 1,0,0,1,... -> words 5468, 6973, 4973, 4E6F, 7457, 6F72, 6B69, 6E67, then checksum 242C. Each word stable while stalled; no word dropped or duplicated.
4. **Resend and checksum off:**
   - After scenario 3, pulse resend -> identical 9-word frame.
   - Repeat with CHECKSUM_EN = 0 -> 8 words, word_last on 6E67.
5. **Overrun:** during word idx 3, drop puf_done for one cycle, then raise it -> overrun = 1 and stays 1. Current frame completes unchanged, no second frame starts.
6. **Reset mid-frame:** assert rst at idx 4 -> outputs 0 within the same cycle. Release with puf_done high -> new frame begins, word 0 = 0x5468.
